// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM state, frame constants, FIFO entry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
  localparam logic [7:0] PS2_CODE_BRK   = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // Odd parity over {parity, d7..d0} holds when the XOR reduction is 1.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver FIFO; master = receiver, slave = consumer.
// Handshake: ready is the head-valid flag; an entry is consumed on every clk edge where
// ready=1 and nextdata_n=0, and data/ext/brk are only meaningful while ready=1.
interface ps2_rx_fifo_if import ps2_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             nextdata_n;
  logic             clr_flags;
  logic [7:0]       data;
  logic             ready;
  logic             overflow;
  logic             parity_err;
  logic             frame_err;
  logic [LVL_W-1:0] level;
  logic             ext;
  logic             brk;
  ps2_state_e       dbg_state;

  modport master (
    input  nextdata_n, clr_flags,
    output data, ready, overflow, parity_err, frame_err, level, ext, brk, dbg_state
  );

  modport slave (
    output nextdata_n, clr_flags,
    input  data, ready, overflow, parity_err, frame_err, level, ext, brk, dbg_state
  );
endinterface

// File: rtl/ps2_rx_fifo_sync_filter.sv
// Synchronises the PS/2 pins, debounces ps2_clk and emits a one-cycle pulse on each
// filtered falling edge together with the synchronised data line.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   r_fall;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  // Everything idles high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_cnt      <= '0;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_filt_d   <= r_filt;
      r_fall     <= r_filt_d & ~r_filt;
      if (w_clk_s == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= w_clk_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a drop-newest scan-code FIFO with sticky error flags.
// Optional feature: define PS2_RX_KEYEVT_EN to fold E0/F0 prefixes into ext/brk entry tags.
module ps2_rx_fifo import ps2_pkg::*; #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_fifo_if.master  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int WDW   = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_RX_KEYEVT_EN
  typedef ps2_entry_t fifo_word_t;
`else
  typedef logic [7:0] fifo_word_t;
`endif

  logic             w_fall;
  logic             w_sdata;
  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic [3:0]       r_bitcnt;
  logic [8:0]       r_sr;
  logic [WDW-1:0]   r_wd;
  logic             w_wd_hit;
  logic             w_frame_ok;
  logic             w_set_par;
  logic             w_set_frm;
  logic             w_push_req;
  fifo_word_t       w_wr_word;
  fifo_word_t       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_ready;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             r_ovf;
  logic             r_par_err;
  logic             r_frm_err;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .clk        (clk),
    .clrn       (clrn),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_sdata)
  );

  assign w_wd_hit = (r_wd == WDW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
    w_set_par   = 1'b0;
    w_set_frm   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall && !w_sdata) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_fall) begin
          if (r_bitcnt == 4'(PS2_FRAME_BITS - 3)) w_state_nxt = STOP;
        end else if (w_wd_hit) begin
          w_state_nxt = IDLE;
          w_set_frm   = 1'b1;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_set_par   = !odd_parity_ok(r_sr);
          w_set_frm   = !w_sdata;
          w_frame_ok  = odd_parity_ok(r_sr) && w_sdata;
        end else if (w_wd_hit) begin
          w_state_nxt = IDLE;
          w_set_frm   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_sr collects d0..d7 then parity LSB-first, so r_sr[7:0] is the byte once in STOP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_sr     <= '0;
      r_wd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE || w_fall) r_wd <= '0;
      else                           r_wd <= r_wd + 1'b1;
      if (r_state == IDLE) begin
        r_bitcnt <= '0;
      end else if (r_state == SHIFT && w_fall) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_sr     <= {w_sdata, r_sr[8:1]};
      end
    end
  end

`ifdef PS2_RX_KEYEVT_EN
  logic r_ext_pend;
  logic r_brk_pend;
  logic w_is_ext;
  logic w_is_brk;

  assign w_is_ext   = w_frame_ok && (r_sr[7:0] == PS2_CODE_EXT);
  assign w_is_brk   = w_frame_ok && (r_sr[7:0] == PS2_CODE_BRK);
  assign w_push_req = w_frame_ok && !w_is_ext && !w_is_brk;
  assign w_wr_word  = '{ext: r_ext_pend, brk: r_brk_pend, code: r_sr[7:0]};

  // Pending prefixes are consumed by the next code byte even if the FIFO drops it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_push_req || w_set_par || w_set_frm) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else begin
      if (w_is_ext) r_ext_pend <= 1'b1;
      if (w_is_brk) r_brk_pend <= 1'b1;
    end
  end

  assign bus.ext = r_mem[r_rptr].ext;
  assign bus.brk = r_mem[r_rptr].brk;
  assign bus.data = r_mem[r_rptr].code;
`else
  assign w_push_req = w_frame_ok;
  assign w_wr_word  = r_sr[7:0];
  assign bus.ext    = 1'b0;
  assign bus.brk    = 1'b0;
  assign bus.data   = r_mem[r_rptr];
`endif

  assign w_ready = (r_level != '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_ready && !bus.nextdata_n;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // A set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ovf     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_drop)              r_ovf <= 1'b1;
      else if (bus.clr_flags)  r_ovf <= 1'b0;
      if (w_set_par)           r_par_err <= 1'b1;
      else if (bus.clr_flags)  r_par_err <= 1'b0;
      if (w_set_frm)           r_frm_err <= 1'b1;
      else if (bus.clr_flags)  r_frm_err <= 1'b0;
    end
  end

  assign bus.ready      = w_ready;
  assign bus.level      = r_level;
  assign bus.overflow   = r_ovf;
  assign bus.parity_err = r_par_err;
  assign bus.frame_err  = r_frm_err;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames on the pins and compares the consumer bus
// against a queue-based model of the received scan codes and sticky flags.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 600;

  logic clk      = 1'b0;
  logic clrn     = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  bit         m_ovf, m_par, m_frm, m_pe, m_pb;
  bit         check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("ready",      32'(bus.ready),      32'(exp_q.size() != 0));
      check("level",      32'(bus.level),      32'(exp_q.size()));
      check("overflow",   32'(bus.overflow),   32'(m_ovf));
      check("parity_err", 32'(bus.parity_err), 32'(m_par));
      check("frame_err",  32'(bus.frame_err),  32'(m_frm));
      check("idle_state", 32'(bus.dbg_state),  32'(IDLE));
      if (exp_q.size() != 0) begin
        check("data", 32'(bus.data), 32'(exp_q[0][7:0]));
        check("ext",  32'(bus.ext),  32'(exp_q[0][9]));
        check("brk",  32'(bus.brk),  32'(exp_q[0][8]));
      end
    end
  end

  // reference model: what a finished frame must do to the queue and flags
  task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
    if (!par_ok)  m_par = 1'b1;
    if (!stop_ok) m_frm = 1'b1;
    if (!par_ok || !stop_ok) begin
      m_pe = 1'b0;
      m_pb = 1'b0;
      return;
    end
`ifdef PS2_RX_KEYEVT_EN
    if (d == 8'hE0) begin m_pe = 1'b1; return; end
    if (d == 8'hF0) begin m_pb = 1'b1; return; end
`endif
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else                       exp_q.push_back({m_pe, m_pb, d});
    m_pe = 1'b0;
    m_pb = 1'b0;
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input bit flip_par, input bit stop_val,
                           input int nbits, input int glitch_bit);
    logic [10:0] bits;
    int half;
    bits = {stop_val, (~^d) ^ flip_par, d, 1'b0};
    check_en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      half = $urandom_range(12, 16);
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        cycles(4);
        ps2_clk = 1'b0;
        cycles(2);
        ps2_clk = 1'b1;
        cycles(half - 6);
      end else begin
        cycles(half);
      end
      ps2_clk = 1'b0;
      cycles(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit flip_par, input bit stop_val,
                       input int glitch_bit);
    send_bits(d, flip_par, stop_val, 11, glitch_bit);
    cycles(30);
    model_frame(d, !flip_par, stop_val);
    check_en = 1'b1;
  endtask

  task automatic pop(input int n);
    bus.nextdata_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    bus.nextdata_n = 1'b1;
  endtask

  task automatic clr();
    bus.clr_flags = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_flags = 1'b0;
    m_ovf = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int kind;
    bus.nextdata_n = 1'b1;
    bus.clr_flags  = 1'b0;
    cycles(5);
    clrn = 1'b1;
    cycles(2);
    check("reset_level", 32'(bus.level),     32'd0);
    check("reset_ready", 32'(bus.ready),     32'd0);
    check("reset_flags", 32'({bus.overflow, bus.parity_err, bus.frame_err}), 32'd0);
    check_en = 1'b1;
    cycles(5);

    // single good frame, then a one-cycle pop
    frame(8'h1C, 1'b0, 1'b1, -1);
    check("t1_data",  32'(bus.data),  32'h1C);
    check("t1_level", 32'(bus.level), 32'd1);
    pop(1);
    check("t1_ready_after_pop", 32'(bus.ready), 32'd0);

    // parity error, then clear
    frame(8'h1C, 1'b1, 1'b1, -1);
    check("t2_parity_err", 32'(bus.parity_err), 32'd1);
    check("t2_level",      32'(bus.level),      32'd0);
    clr();
    check("t2_parity_clr", 32'(bus.parity_err), 32'd0);

    // fill past full: ninth byte is dropped
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1, -1);
    check("t3_level",    32'(bus.level),    32'd8);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_order", 32'(bus.data), 32'(i));
      pop(1);
    end
    check("t3_empty", 32'(bus.ready), 32'd0);
    clr();

    // truncated frame trips the watchdog
    send_bits(8'h33, 1'b0, 1'b1, 5, -1);
    cycles(TO + 10);
    m_frm = 1'b1;
    m_pe  = 1'b0;
    m_pb  = 1'b0;
    check_en = 1'b1;
    check("t4_frame_err", 32'(bus.frame_err), 32'd1);
    check("t4_idle",      32'(bus.dbg_state), 32'(IDLE));
    frame(8'h29, 1'b0, 1'b1, -1);
    check("t4_next_data", 32'(bus.data), 32'h29);
    pop(1);
    clr();

    // short low glitch on ps2_clk mid-frame
    frame(8'h5A, 1'b0, 1'b1, 4);
    check("t5_data",  32'(bus.data),  32'h5A);
    check("t5_level", 32'(bus.level), 32'd1);
    pop(1);

    // extended break sequence
    frame(8'hE0, 1'b0, 1'b1, -1);
    frame(8'hF0, 1'b0, 1'b1, -1);
    frame(8'h75, 1'b0, 1'b1, -1);
`ifdef PS2_RX_KEYEVT_EN
    check("t6_level", 32'(bus.level), 32'd1);
    check("t6_data",  32'(bus.data),  32'h75);
    check("t6_tags",  32'({bus.ext, bus.brk}), 32'd3);
`else
    check("t6_level", 32'(bus.level), 32'd3);
    check("t6_data",  32'(bus.data),  32'hE0);
    check("t6_tags",  32'({bus.ext, bus.brk}), 32'd0);
`endif
    pop(4);

    // randomized frames, errors, pops and clears
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
      kind = $urandom_range(0, 9);
      frame(d, (kind == 0 || kind == 2), !(kind == 1 || kind == 2), -1);
      if ($urandom_range(0, 2) == 0) pop($urandom_range(1, 4));
      if ($urandom_range(0, 6) == 0) clr();
    end
    pop(DEPTH + 2);
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
